bounce_counter_p: RTL and testbench

Parametrised up/down "bounce" counter that sweeps between programmable lower and upper bounds. Supports four modes: triangle bounce, up-wrap, down-wrap and one-shot. Step size is programmable, and the block provides a synchronous load, a turn pulse and a saturating period count. It is the general successor to the fixed 3-bit 0..7..0 triangle counter and serves as a reusable sweep/pattern generator for test and PWM-style logic.

---
 rtl/bounce_counter_pkg.sv | 24 ++
 rtl/bounce_step_calc.sv | 44 ++++
 rtl/bounce_counter_p.sv | 159 +++++++++++++++
 tb/tb_bounce_counter_p.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_counter_pkg.sv
// Shared types and helpers for the bounce/sweep counter.
// Mode encoding matches the 2-bit mode port directly.
package bounce_counter_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'd0,
    MODE_UP_WRAP   = 2'd1,
    MODE_DOWN_WRAP = 2'd2,
    MODE_ONE_SHOT  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // BOUNCE keeps whatever direction it was travelling; every other mode pins it.
  function automatic logic mode_dir(mode_e m, logic cur);
    case (m)
      MODE_BOUNCE:    return cur;
      MODE_DOWN_WRAP: return DIR_DOWN;
      default:        return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/bounce_step_calc.sv
// Combinational next-value arithmetic for the bounce counter: clamped
// up/down steps and bound comparisons, evaluated in an extended width.
module bounce_step_calc #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  output logic [WIDTH-1:0]  up_nxt,
  output logic [WIDTH-1:0]  dn_nxt,
  output logic [WIDTH-1:0]  nxt,
  output logic              at_hi,
  output logic              at_lo,
  output logic              out_of_range
);

  // One guard bit above the wider operand so a carry or borrow is always visible.
  localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [CW-1:0] cnt_x, lo_x, hi_x, step_x, sum_x, diff_x;
  logic          borrow;

  always_comb begin
    cnt_x  = CW'(count);
    lo_x   = CW'(lo);
    hi_x   = CW'(hi);
    step_x = CW'(step);
    sum_x  = cnt_x + step_x;
    diff_x = cnt_x - step_x;
    borrow = step_x > cnt_x;

    up_nxt = (sum_x > hi_x) ? hi : sum_x[WIDTH-1:0];
    dn_nxt = (borrow || (diff_x < lo_x)) ? lo : diff_x[WIDTH-1:0];
    nxt    = dir ? up_nxt : dn_nxt;

    at_hi        = (count == hi);
    at_lo        = (count == lo);
    out_of_range = (count < lo) || (count > hi);
  end

endmodule

// File: rtl/bounce_counter_p.sv
// Programmable up/down sweep counter with bounce, wrap and one-shot modes,
// synchronous load, turn pulse and a saturating completed-sweep count.
module bounce_counter_p
  import bounce_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              turn,
  output logic              done,
  output logic              bad_cfg,
  output logic [PER_W-1:0]  periods
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             done_q, done_d;
  logic [PER_W-1:0] periods_q, periods_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] up_nxt, dn_nxt, nxt;
  logic             at_hi, at_lo, out_of_range;
  logic             mode_changed, done_eff, per_inc;
  mode_e            mode_cur;

  bounce_step_calc #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) u_step_calc (
    .count       (count_q),
    .lo          (lo),
    .hi          (hi),
    .step        (step),
    .dir         (dir_q),
    .up_nxt      (up_nxt),
    .dn_nxt      (dn_nxt),
    .nxt         (nxt),
    .at_hi       (at_hi),
    .at_lo       (at_lo),
    .out_of_range(out_of_range)
  );

  assign bad_cfg = (lo > hi);

  always_comb begin
    mode_cur     = mode_e'(mode);
    mode_changed = (mode != mode_q);
    // A mode change cancels a finished one-shot in the same cycle it is seen.
    done_eff     = done_q & ~mode_changed;

    count_d   = count_q;
    dir_d     = dir_q;
    turn_d    = 1'b0;
    done_d    = done_eff;
    mode_d    = mode;
    per_inc   = 1'b0;

    if (load) begin
      count_d = load_val;
      dir_d   = (mode_cur == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
      done_d  = 1'b0;
    end else if (bad_cfg) begin
      count_d = count_q;
    end else if (en) begin
      dir_d = mode_dir(mode_cur, dir_q);
      if (out_of_range) begin
        count_d = (mode_cur == MODE_DOWN_WRAP) ? hi : lo;
      end else if (lo == hi) begin
        count_d = lo;
      end else if (step != '0) begin
        case (mode_cur)
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP && at_hi) begin
              count_d = dn_nxt;
              dir_d   = DIR_DOWN;
              turn_d  = 1'b1;
            end else if (dir_q == DIR_DOWN && at_lo) begin
              count_d = up_nxt;
              dir_d   = DIR_UP;
              turn_d  = 1'b1;
              per_inc = 1'b1;
            end else begin
              count_d = nxt;
            end
          end
          MODE_UP_WRAP: begin
            if (at_hi) begin
              count_d = lo;
              turn_d  = 1'b1;
              per_inc = 1'b1;
            end else begin
              count_d = up_nxt;
            end
          end
          MODE_DOWN_WRAP: begin
            if (at_lo) begin
              count_d = hi;
              turn_d  = 1'b1;
              per_inc = 1'b1;
            end else begin
              count_d = dn_nxt;
            end
          end
          MODE_ONE_SHOT: begin
            // done rises together with the first displayed hi, and the count parks there.
            if (!done_eff) begin
              count_d = up_nxt;
              if (up_nxt == hi) begin
                done_d  = 1'b1;
                per_inc = 1'b1;
              end
            end
          end
          default: count_d = count_q;
        endcase
      end
    end

    periods_d = (per_inc && (periods_q != '1)) ? periods_q + PER_W'(1) : periods_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      dir_q     <= DIR_UP;
      turn_q    <= 1'b0;
      done_q    <= 1'b0;
      periods_q <= '0;
      mode_q    <= MODE_BOUNCE;
    end else begin
      count_q   <= count_d;
      dir_q     <= dir_d;
      turn_q    <= turn_d;
      done_q    <= done_d;
      periods_q <= periods_d;
      mode_q    <= mode_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign turn    = turn_q;
  assign done    = done_q;
  assign periods = periods_q;

endmodule

// File: tb/tb_bounce_counter_p.sv
// Bench for bounce_counter_p: directed sweeps from the test plan plus random
// traffic, checked against an integer reference model (8-bit and 3-bit/2-bit-period instances).
module tb_bounce_counter_p;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] lo, hi, load_val;
  logic [3:0] step;
  logic       load;

  logic [7:0]  count;
  logic        dir, turn, done, bad_cfg;
  logic [15:0] periods;

  logic [2:0]  s_count;
  logic        s_dir, s_turn, s_done, s_bad_cfg;
  logic [1:0]  s_periods;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int count;
    int dir;
    int turn;
    int done;
    int periods;
    int mode_prev;
  } mst_t;

  mst_t m, sm;

  bounce_counter_p #(.WIDTH(8), .STEP_W(4), .PER_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi), .step(step),
    .load(load), .load_val(load_val), .count(count), .dir(dir), .turn(turn),
    .done(done), .bad_cfg(bad_cfg), .periods(periods)
  );

  bounce_counter_p #(.WIDTH(3), .STEP_W(4), .PER_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo[2:0]), .hi(hi[2:0]), .step(step),
    .load(load), .load_val(load_val[2:0]), .count(s_count), .dir(s_dir), .turn(s_turn),
    .done(s_done), .bad_cfg(s_bad_cfg), .periods(s_periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic mst_t reset_state();
    mst_t r;
    r.count = 0; r.dir = 1; r.turn = 0; r.done = 0; r.periods = 0; r.mode_prev = 0;
    return r;
  endfunction

  // Reference behaviour written from the rules with plain integers and min/max.
  function automatic mst_t mstep(mst_t s, int e, int md, int l, int h, int st,
                                 int ld, int lv, int pmax);
    mst_t n = s;
    int up, dn;
    bit bump = 0;
    n.turn = 0;
    n.mode_prev = md;
    if (md != s.mode_prev) n.done = 0;
    if (ld != 0) begin
      n.count = lv; n.dir = (md == 2) ? 0 : 1; n.done = 0;
      return n;
    end
    if (l > h || e == 0) return n;
    if (md == 2) n.dir = 0; else if (md != 0) n.dir = 1;
    if (s.count < l || s.count > h) begin
      n.count = (md == 2) ? h : l;
      return n;
    end
    if (l == h) begin
      n.count = l;
      return n;
    end
    if (st == 0) return n;
    up = (s.count + st > h) ? h : s.count + st;
    dn = (s.count - st < l) ? l : s.count - st;
    case (md)
      0: begin
        if (s.dir == 1 && s.count == h) begin
          n.count = dn; n.dir = 0; n.turn = 1;
        end else if (s.dir == 0 && s.count == l) begin
          n.count = up; n.dir = 1; n.turn = 1; bump = 1;
        end else begin
          n.count = (s.dir == 1) ? up : dn;
        end
      end
      1: begin
        if (s.count == h) begin n.count = l; n.turn = 1; bump = 1; end
        else n.count = up;
      end
      2: begin
        if (s.count == l) begin n.count = h; n.turn = 1; bump = 1; end
        else n.count = dn;
      end
      default: begin
        if (n.done == 0) begin
          n.count = up;
          if (up == h) begin n.done = 1; bump = 1; end
        end
      end
    endcase
    if (bump && n.periods < pmax) n.periods++;
    return n;
  endfunction

  task automatic compare_all();
    check("count", int'(count), m.count);
    check("dir", int'(dir), m.dir);
    check("turn", int'(turn), m.turn);
    check("done", int'(done), m.done);
    check("periods", int'(periods), m.periods);
    check("bad_cfg", int'(bad_cfg), (lo > hi) ? 1 : 0);
    check("s_count", int'(s_count), sm.count);
    check("s_dir", int'(s_dir), sm.dir);
    check("s_turn", int'(s_turn), sm.turn);
    check("s_done", int'(s_done), sm.done);
    check("s_periods", int'(s_periods), sm.periods);
    check("s_bad_cfg", int'(s_bad_cfg), (lo[2:0] > hi[2:0]) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m  = reset_state();
      sm = reset_state();
    end else begin
      m  = mstep(m, int'(en), int'(mode), int'(lo), int'(hi), int'(step),
                 int'(load), int'(load_val), 65535);
      sm = mstep(sm, int'(en), int'(mode), int'(lo[2:0]), int'(hi[2:0]), int'(step),
                 int'(load), int'(load_val[2:0]), 3);
    end
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [1:0] md, input logic [7:0] l, input logic [7:0] h,
                         input logic [3:0] st, input logic [7:0] v);
    mode = md; lo = l; hi = h; step = st; load_val = v; load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
  endtask

  int exp1[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int exp2[7]  = '{14, 18, 20, 16, 12, 10, 14};
  int exp3[5]  = '{4, 5, 3, 4, 5};
  int exp4[4]  = '{4, 3, 5, 4};
  int exp5[4]  = '{3, 4, 4, 4};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; lo = 8'd0; hi = 8'd7; step = 4'd1;
    load = 1'b0; load_val = 8'd0;
    m = reset_state();
    sm = reset_state();

    #12;
    check("rst_count", int'(count), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_turn", int'(turn), 0);
    check("rst_done", int'(done), 0);
    check("rst_periods", int'(periods), 0);
    #5 rst = 1'b1;

    // Triangle 0..7..0 on the 3-bit instance.
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("tri_count", int'(s_count), exp1[i]);
      check("tri_turn", int'(s_turn), (i == 7 || i == 14) ? 1 : 0);
    end
    check("tri_periods", int'(s_periods), 1);

    do_load(2'd0, 8'd10, 8'd20, 4'd4, 8'd10);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("b4_count", int'(count), exp2[i]);
      check("b4_turn", int'(turn), (i == 3 || i == 6) ? 1 : 0);
    end

    do_load(2'd1, 8'd3, 8'd5, 4'd1, 8'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("upw_count", int'(count), exp3[i]);
      check("upw_dir", int'(dir), 1);
    end

    do_load(2'd2, 8'd3, 8'd5, 4'd1, 8'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dnw_count", int'(count), exp4[i]);
      check("dnw_dir", int'(dir), 0);
    end

    do_load(2'd3, 8'd0, 8'd4, 4'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("os_count", int'(count), exp5[i]);
      check("os_done", int'(done), (i >= 1) ? 1 : 0);
    end
    do_load(2'd3, 8'd0, 8'd4, 4'd3, 8'd0);
    check("os_reload_done", int'(done), 0);
    tick();
    check("os_restart", int'(count), 3);

    do_load(2'd0, 8'd0, 8'd7, 4'd1, 8'd200);
    check("ld200_count", int'(count), 200);
    tick();
    check("ld200_next", int'(count), 0);
    check("ld200_turn", int'(turn), 0);

    lo = 8'd9; hi = 8'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bad_flag", int'(bad_cfg), 1);
      check("bad_frozen", int'(count), 0);
    end

    lo = 8'd5; hi = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("deg_count", int'(count), 5);
    end

    // Asynchronous reset while sweeping down from 7.
    do_load(2'd0, 8'd0, 8'd7, 4'd1, 8'd0);
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_count", int'(count), 6);
    check("pre_rst_dir", int'(dir), 0);
    #2 rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_dir", int'(dir), 1);
    check("arst_turn", int'(turn), 0);
    check("arst_periods", int'(periods), 0);
    tick();
    #2 rst = 1'b1;
    tick();
    check("rel_count1", int'(count), 1);
    tick();
    check("rel_count2", int'(count), 2);

    // Period saturation on the 2-bit counter.
    do_load(2'd1, 8'd0, 8'd1, 4'd1, 8'd0);
    for (int i = 0; i < 12; i++) tick();
    check("sat_periods", int'(s_periods), 3);

    // Random traffic.
    lo = 8'd20; hi = 8'd200;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        logic [7:0] a, b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0 && a > b) begin lo = b; hi = a; end
        else begin lo = a; hi = b; end
      end
      step     = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = 8'($urandom_range(0, 255));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
